// File: rtl/noc_arb_pkg.sv
// noc_arb_pkg: shared types and helpers for the NoC output arbiter.
//   - arb_state_t : arbiter FSM state encoding
//   - HDR_*       : header word field offsets
//   - build_header: assembles the packet header word from dest, source and length
package noc_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_HDR  = 2'd1,
    ARB_PAY  = 2'd2
  } arb_state_t;

  // Destination {y,x} sits at the bottom of the header, the source tile id
  // directly above it (offset 2*XY_SZ), and the length in the top byte.
  localparam int HDR_DST_LSB = 0;
  localparam int HDR_LEN_LSB = 24;
  localparam int HDR_LEN_W   = 8;

  // dst_yx / src_yx arrive zero-extended to 12 bits (max XY_SZ = 6); xy_sz
  // selects where the source id lands. len arrives zero-extended to 8 bits.
  function automatic logic [31:0] build_header(input logic [11:0] dst_yx,
                                               input logic [11:0] src_yx,
                                               input logic [7:0]  len,
                                               input int          xy_sz);
    logic [31:0] hdr;
    logic [31:0] yx_mask;
    yx_mask = (32'd1 << (2 * xy_sz)) - 32'd1;
    hdr = ({20'd0, dst_yx} & yx_mask) << HDR_DST_LSB;
    hdr = hdr | (({20'd0, src_yx} & yx_mask) << (2 * xy_sz));
    hdr[HDR_LEN_LSB +: HDR_LEN_W] = len;
    return hdr;
  endfunction

endpackage

// File: rtl/noc_out_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
// Searches req upward starting at ptr, wrapping at N_REQ, and returns the
// first set position.
//   req   : request vector
//   ptr   : search start index
//   grant : one-hot of the chosen requester (all zero when none)
//   idx   : index of the chosen requester (0 when none)
//   any   : at least one request present
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      pos = (int'(ptr) + i) % N_REQ;
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/noc_out_arbiter.sv
// noc_out_arbiter: round-robin scheduler sharing one tile NoC AXI-stream
// output among N_REQ packet sources. A granted source gets a generated header
// word followed by a combinational passthrough of its payload words, with
// TLAST on the final word.
//
// Optional watchdog: define NOC_ARB_WDOG_EN. A grantee that leaves its
// payload stalled for WDOG_CYC cycles gets its packet padded with zero words
// and wdog_err is raised (sticky). Without the macro wdog_err is tied low.
//
// Ports:
//   clk_line, clk_line_rst_low : line clock, synchronous active-low reset
//   HsrcId                     : own tile id {y,x}, placed in every header
//   req_valid/x_dest/y_dest/len: per-requester packet request (held until ack)
//   req_ack                    : one-cycle pulse, request latched
//   src_valid/src_data/src_ready : per-requester payload stream
//   stream_out_*               : NoC AXI-stream output
//   busy                       : packet in flight
//   grant_id                   : current grantee, 0 when idle
//   wdog_err                   : sticky watchdog flag
//   state_dbg                  : current FSM state (arb_state_t encoding)
//
// Handshake: every stream (stream_out_*, src_*) transfers a word on a cycle
// where valid and ready are both high; valid and data hold steady until then.
module noc_out_arbiter
  import noc_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int XY_SZ    = 4,
  parameter int LEN_SZ   = 8,
  parameter int WDOG_CYC = 64
) (
  input  logic                    clk_line,
  input  logic                    clk_line_rst_low,
  input  logic [2*XY_SZ-1:0]      HsrcId,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*XY_SZ-1:0]  req_x_dest,
  input  logic [N_REQ*XY_SZ-1:0]  req_y_dest,
  input  logic [N_REQ*LEN_SZ-1:0] req_len,
  output logic [N_REQ-1:0]        req_ack,
  input  logic [N_REQ-1:0]        src_valid,
  input  logic [N_REQ*32-1:0]     src_data,
  output logic [N_REQ-1:0]        src_ready,
  input  logic                    stream_out_TREADY,
  output logic                    stream_out_TVALID,
  output logic [31:0]             stream_out_TDATA,
  output logic [3:0]              stream_out_TKEEP,
  output logic                    stream_out_TLAST,
  output logic                    busy,
  output logic [2:0]              grant_id,
  output logic                    wdog_err,
  output logic [1:0]              state_dbg
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [31:0]       hdr_q;
  logic [LEN_SZ-1:0] len_q;
  logic [LEN_SZ-1:0] cnt;

  logic [N_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  logic [XY_SZ-1:0]  sel_x;
  logic [XY_SZ-1:0]  sel_y;
  logic [LEN_SZ-1:0] sel_len;

  logic [IDX_W-1:0]  cur;
  logic [IDX_W-1:0]  nxt_ptr;
  logic              cur_valid;
  logic [31:0]       cur_data;
  logic              hs;
  logic              pay_last;
  logic              pad_active;

  assign state_dbg = state;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_onehot),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Fields of the requester about to be granted.
  always_comb begin
    sel_x   = req_x_dest[int'(pick_idx)*XY_SZ +: XY_SZ];
    sel_y   = req_y_dest[int'(pick_idx)*XY_SZ +: XY_SZ];
    sel_len = req_len[int'(pick_idx)*LEN_SZ +: LEN_SZ];
  end

  // grant_id is held for the whole packet, so it doubles as the mux select.
  assign cur       = grant_id[IDX_W-1:0];
  assign cur_valid = src_valid[cur];
  assign cur_data  = src_data[int'(cur)*32 +: 32];
  assign nxt_ptr   = (cur == IDX_W'(N_REQ - 1)) ? '0 : cur + IDX_W'(1);

  // Output stream: header from a register in HDR, grantee passthrough in PAY.
  always_comb begin
    stream_out_TVALID = 1'b0;
    stream_out_TDATA  = 32'd0;
    stream_out_TLAST  = 1'b0;
    src_ready         = '0;
    case (state)
      ARB_HDR: begin
        stream_out_TVALID = 1'b1;
        stream_out_TDATA  = hdr_q;
        stream_out_TLAST  = (len_q == '0);
      end
      ARB_PAY: begin
        stream_out_TLAST = (cnt == LEN_SZ'(1));
        if (pad_active) begin
          // Watchdog padding: zero words, grantee no longer consulted.
          stream_out_TVALID = 1'b1;
        end else begin
          stream_out_TVALID = cur_valid;
          stream_out_TDATA  = cur_data;
          src_ready[cur]    = stream_out_TREADY;
        end
      end
      default: ;
    endcase
  end

  assign stream_out_TKEEP = stream_out_TVALID ? 4'hF : 4'h0;
  assign hs               = stream_out_TVALID && stream_out_TREADY;
  assign pay_last         = (state == ARB_PAY) && hs && (cnt == LEN_SZ'(1));

  always_ff @(posedge clk_line) begin
    if (!clk_line_rst_low) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      hdr_q    <= 32'd0;
      len_q    <= '0;
      cnt      <= '0;
      req_ack  <= '0;
      busy     <= 1'b0;
      grant_id <= 3'd0;
    end else begin
      req_ack <= '0;
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            req_ack  <= pick_onehot;
            hdr_q    <= build_header(12'({sel_y, sel_x}), 12'(HsrcId),
                                     8'(sel_len), XY_SZ);
            len_q    <= sel_len;
            grant_id <= 3'(pick_idx);
            busy     <= 1'b1;
            state    <= ARB_HDR;
          end
        end
        ARB_HDR: begin
          if (stream_out_TREADY) begin
            if (len_q == '0) begin
              state    <= ARB_IDLE;
              busy     <= 1'b0;
              grant_id <= 3'd0;
              rr_ptr   <= nxt_ptr;
            end else begin
              cnt   <= len_q;
              state <= ARB_PAY;
            end
          end
        end
        ARB_PAY: begin
          if (hs) begin
            cnt <= cnt - LEN_SZ'(1);
          end
          if (pay_last) begin
            state    <= ARB_IDLE;
            busy     <= 1'b0;
            grant_id <= 3'd0;
            rr_ptr   <= nxt_ptr;
          end
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

`ifdef NOC_ARB_WDOG_EN
  localparam int STALL_W = $clog2(WDOG_CYC + 1);

  logic [STALL_W-1:0] stall_cnt;
  logic               pad_q;

  assign pad_active = pad_q;

  // Only source stalls (grantee src_valid low) count; TREADY stalls with
  // data present are the NoC's business and never trip the watchdog.
  always_ff @(posedge clk_line) begin
    if (!clk_line_rst_low) begin
      stall_cnt <= '0;
      pad_q     <= 1'b0;
      wdog_err  <= 1'b0;
    end else if (state == ARB_PAY) begin
      if (pay_last) begin
        stall_cnt <= '0;
        pad_q     <= 1'b0;
        if (pad_q) begin
          wdog_err <= 1'b1;
        end
      end else if (!pad_q) begin
        if (hs) begin
          stall_cnt <= '0;
        end else if (!cur_valid) begin
          if (stall_cnt == STALL_W'(WDOG_CYC - 1)) begin
            pad_q     <= 1'b1;
            stall_cnt <= '0;
          end else begin
            stall_cnt <= stall_cnt + STALL_W'(1);
          end
        end
      end
    end
  end
`else
  assign pad_active = 1'b0;
  assign wdog_err   = 1'b0;
`endif

endmodule

// File: tb/tb_noc_out_arbiter.sv
// tb_noc_out_arbiter: directed self-checking bench for noc_out_arbiter
// (N_REQ=4, XY_SZ=4, LEN_SZ=8, WDOG_CYC=8). Build with NOC_ARB_WDOG_EN to
// exercise the watchdog scenario.
//
// Cycle discipline: step() moves to just after a rising edge, where inputs
// for the new cycle are set; sample() then applies TREADY and source data,
// waits 1ns and records handshakes. Checks run at the sample point.
// Each source i presents word(i, k) as its k-th payload word.
module tb_noc_out_arbiter;

  logic         clk_line = 1'b0;
  logic         clk_line_rst_low;
  logic [7:0]   HsrcId;
  logic [3:0]   req_valid;
  logic [15:0]  req_x_dest;
  logic [15:0]  req_y_dest;
  logic [31:0]  req_len;
  logic [3:0]   req_ack;
  logic [3:0]   src_valid;
  logic [127:0] src_data;
  logic [3:0]   src_ready;
  logic         stream_out_TREADY;
  logic         stream_out_TVALID;
  logic [31:0]  stream_out_TDATA;
  logic [3:0]   stream_out_TKEEP;
  logic         stream_out_TLAST;
  logic         busy;
  logic [2:0]   grant_id;
  logic         wdog_err;
  logic [1:0]   state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] beat_d[$];
  logic        beat_l[$];
  logic [31:0] exp_q[$];
  logic        exp_l[$];
  int          ack_order[$];
  int          ack_cnt[4];
  int          widx[4];

  // ---------------- clock / reset ----------------
  always #5 clk_line = ~clk_line;

  noc_out_arbiter #(
    .N_REQ    (4),
    .XY_SZ    (4),
    .LEN_SZ   (8),
    .WDOG_CYC (8)
  ) dut (
    .clk_line          (clk_line),
    .clk_line_rst_low  (clk_line_rst_low),
    .HsrcId            (HsrcId),
    .req_valid         (req_valid),
    .req_x_dest        (req_x_dest),
    .req_y_dest        (req_y_dest),
    .req_len           (req_len),
    .req_ack           (req_ack),
    .src_valid         (src_valid),
    .src_data          (src_data),
    .src_ready         (src_ready),
    .stream_out_TREADY (stream_out_TREADY),
    .stream_out_TVALID (stream_out_TVALID),
    .stream_out_TDATA  (stream_out_TDATA),
    .stream_out_TKEEP  (stream_out_TKEEP),
    .stream_out_TLAST  (stream_out_TLAST),
    .busy              (busy),
    .grant_id          (grant_id),
    .wdog_err          (wdog_err),
    .state_dbg         (state_dbg)
  );

  function automatic logic [31:0] word(input int r, input int k);
    return {4'hA, 4'(r), 8'h5A, 16'(k)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_line);
    #1;
  endtask

  task automatic sample(input logic tr);
    stream_out_TREADY = tr;
    for (int r = 0; r < 4; r++) src_data[r*32 +: 32] = word(r, widx[r]);
    #1;
    if (stream_out_TVALID && stream_out_TREADY) begin
      beat_d.push_back(stream_out_TDATA);
      beat_l.push_back(stream_out_TLAST);
    end
    for (int r = 0; r < 4; r++) begin
      if (req_ack[r]) begin
        ack_cnt[r]++;
        ack_order.push_back(r);
        req_valid[r] = 1'b0;
      end
      if (src_ready[r] && src_valid[r]) widx[r]++;
    end
  endtask

  task automatic cycle(input logic tr);
    step();
    sample(tr);
  endtask

  task automatic set_req(input int r, input int x, input int y, input int len);
    req_x_dest[r*4 +: 4] = 4'(x);
    req_y_dest[r*4 +: 4] = 4'(y);
    req_len[r*8 +: 8]    = 8'(len);
  endtask

  // Leaves the bench just after a rising edge with reset released.
  task automatic do_reset();
    clk_line_rst_low  = 1'b0;
    req_valid         = '0;
    src_valid         = '0;
    stream_out_TREADY = 1'b0;
    HsrcId            = 8'h11;
    req_x_dest        = '0;
    req_y_dest        = '0;
    req_len           = '0;
    src_data          = '0;
    repeat (2) @(posedge clk_line);
    #1;
    clk_line_rst_low = 1'b1;
    beat_d.delete();
    beat_l.delete();
    ack_order.delete();
    for (int r = 0; r < 4; r++) begin
      ack_cnt[r] = 0;
      widx[r]    = 0;
    end
    src_valid = 4'hF;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clk_line_rst_low  = 1'b0;
    req_valid         = '0;
    src_valid         = '0;
    HsrcId            = 8'h11;
    req_x_dest        = '0;
    req_y_dest        = '0;
    req_len           = '0;
    for (int r = 0; r < 4; r++) widx[r] = 0;
    step();
    sample(1'b0);
    tests_run++;
    if ({stream_out_TVALID, stream_out_TLAST, stream_out_TKEEP} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctl: got valid/last/keep %b expected 0", {stream_out_TVALID, stream_out_TLAST, stream_out_TKEEP});
    end
    tests_run++;
    if (stream_out_TDATA !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_tdata: got %h expected 0", stream_out_TDATA);
    end
    tests_run++;
    if ({req_ack, src_ready} !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_ack_ready: got %b expected 0", {req_ack, src_ready});
    end
    tests_run++;
    if ({busy, grant_id, wdog_err, state_dbg} !== 7'd0) begin
      tests_failed++;
      $display("FAIL reset_status: got %b expected 0", {busy, grant_id, wdog_err, state_dbg});
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    set_req(1, 2, 3, 3);
    req_valid = 4'b0010;
    sample(1'b1);
    tests_run++;
    if (stream_out_TVALID !== 1'b0 || req_ack !== 4'b0000) begin
      tests_failed++;
      $display("FAIL single_c0: got valid %b ack %b expected 0 0000", stream_out_TVALID, req_ack);
    end
    cycle(1'b1);
    tests_run++;
    if (req_ack !== 4'b0010 || stream_out_TVALID !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_c1: got ack %b valid %b expected 0010 1", req_ack, stream_out_TVALID);
    end
    tests_run++;
    if (stream_out_TDATA !== 32'h03001132 || stream_out_TKEEP !== 4'hF) begin
      tests_failed++;
      $display("FAIL single_hdr: got %h keep %h expected 03001132 f", stream_out_TDATA, stream_out_TKEEP);
    end
    tests_run++;
    if (busy !== 1'b1 || grant_id !== 3'd1 || src_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL single_hdr_status: got busy %b gid %0d rdy %b expected 1 1 0000", busy, grant_id, src_ready);
    end
    cycle(1'b1);
    tests_run++;
    if (src_ready !== 4'b0010) begin
      tests_failed++;
      $display("FAIL single_src_ready: got %b expected 0010", src_ready);
    end
    repeat (3) cycle(1'b1);
    tests_run++;
    if (busy !== 1'b0 || grant_id !== 3'd0 || ack_cnt[1] != 1) begin
      tests_failed++;
      $display("FAIL single_end: got busy %b gid %0d acks %0d expected 0 0 1", busy, grant_id, ack_cnt[1]);
    end
    exp_q = '{32'h03001132, word(1, 0), word(1, 1), word(1, 2)};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
    tests_run++;
    if (beat_d.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL single_count: got %0d beats expected %0d", beat_d.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < beat_d.size(); i++) begin
      tests_run++;
      if (beat_d[i] !== exp_q[i] || beat_l[i] !== exp_l[i]) begin
        tests_failed++;
        $display("FAIL single_beat%0d: got %h/%b expected %h/%b", i, beat_d[i], beat_l[i], exp_q[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < 4; r++) set_req(r, r, r, 1);
    req_valid = 4'b1111;
    sample(1'b1);
    repeat (12) cycle(1'b1);
    exp_q = '{32'h01001100, word(0, 0), 32'h01001111, word(1, 0),
              32'h01001122, word(2, 0), 32'h01001133, word(3, 0)};
    exp_l = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tests_run++;
    if (beat_d.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL rr_count: got %0d beats expected %0d", beat_d.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < beat_d.size(); i++) begin
      tests_run++;
      if (beat_d[i] !== exp_q[i] || beat_l[i] !== exp_l[i]) begin
        tests_failed++;
        $display("FAIL rr_beat%0d: got %h/%b expected %h/%b", i, beat_d[i], beat_l[i], exp_q[i], exp_l[i]);
      end
    end
    step();
    req_valid = 4'b1111;
    sample(1'b1);
    cycle(1'b1);
    tests_run++;
    if (ack_order.size() != 5) begin
      tests_failed++;
      $display("FAIL rr_acks: got %0d acks expected 5", ack_order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (ack_order[i] != (i % 4)) begin
          tests_failed++;
          $display("FAIL rr_order%0d: got %0d expected %0d", i, ack_order[i], i % 4);
        end
      end
    end
  endtask

  task automatic test_len_zero();
    do_reset();
    set_req(2, 2, 2, 0);
    req_valid = 4'b0100;
    sample(1'b1);
    cycle(1'b1);
    tests_run++;
    if (stream_out_TDATA !== 32'h00001122 || stream_out_TLAST !== 1'b1 || stream_out_TVALID !== 1'b1) begin
      tests_failed++;
      $display("FAIL len0_hdr: got %h last %b valid %b expected 00001122 1 1", stream_out_TDATA, stream_out_TLAST, stream_out_TVALID);
    end
    cycle(1'b1);
    tests_run++;
    if (busy !== 1'b0 || beat_d.size() != 1) begin
      tests_failed++;
      $display("FAIL len0_end: got busy %b beats %0d expected 0 1", busy, beat_d.size());
    end
    // rr_ptr must now be 3: with 0 and 3 pending, 3 wins.
    step();
    set_req(0, 0, 0, 0);
    set_req(3, 0, 0, 0);
    req_valid = 4'b1001;
    sample(1'b1);
    cycle(1'b1);
    tests_run++;
    if (ack_order.size() != 2 || ack_order[ack_order.size()-1] != 3) begin
      tests_failed++;
      $display("FAIL len0_rrptr: got last grant %0d of %0d expected 3 of 2", ack_order[ack_order.size()-1], ack_order.size());
    end
  endtask

  task automatic test_backpressure();
    logic        tr;
    logic [31:0] prev_d;
    do_reset();
    set_req(0, 1, 2, 4);
    req_valid = 4'b0001;
    sample(1'b1);
    cycle(1'b1);
    prev_d = stream_out_TDATA;
    for (int i = 0; i < 7; i++) begin
      tr = (i % 2 == 0);
      cycle(tr);
      tests_run++;
      if (src_ready !== {3'b000, tr}) begin
        tests_failed++;
        $display("FAIL bp_ready%0d: got %b expected %b", i, src_ready, {3'b000, tr});
      end
      if (i % 2 == 0 && i > 0) begin
        tests_run++;
        if (stream_out_TDATA !== prev_d || stream_out_TVALID !== 1'b1) begin
          tests_failed++;
          $display("FAIL bp_stable%0d: got %h valid %b expected %h 1", i, stream_out_TDATA, stream_out_TVALID, prev_d);
        end
      end
      prev_d = stream_out_TDATA;
    end
    cycle(1'b1);
    exp_q = '{32'h04001121, word(0, 0), word(0, 1), word(0, 2), word(0, 3)};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tests_run++;
    if (beat_d.size() != exp_q.size() || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d beats busy %b expected %0d 0", beat_d.size(), busy, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < beat_d.size(); i++) begin
      tests_run++;
      if (beat_d[i] !== exp_q[i] || beat_l[i] !== exp_l[i]) begin
        tests_failed++;
        $display("FAIL bp_beat%0d: got %h/%b expected %h/%b", i, beat_d[i], beat_l[i], exp_q[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(1, 0, 0, 0);
    req_valid = 4'b0010;
    sample(1'b1);
    cycle(1'b1);
    cycle(1'b1);
    step();
    set_req(2, 1, 1, 5);
    req_valid = 4'b0100;
    sample(1'b1);
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b1);
    step();
    clk_line_rst_low = 1'b0;
    sample(1'b0);
    tests_run++;
    if (beat_d.size() != 4 || busy !== 1'b1 || grant_id !== 3'd2) begin
      tests_failed++;
      $display("FAIL rstmid_pre: got beats %0d busy %b gid %0d expected 4 1 2", beat_d.size(), busy, grant_id);
    end
    step();
    clk_line_rst_low = 1'b1;
    sample(1'b1);
    tests_run++;
    if (stream_out_TVALID !== 1'b0 || busy !== 1'b0 || grant_id !== 3'd0 || stream_out_TLAST !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_post: got valid %b busy %b gid %0d last %b expected 0 0 0 0", stream_out_TVALID, busy, grant_id, stream_out_TLAST);
    end
    ack_order.delete();
    step();
    set_req(0, 0, 0, 0);
    set_req(3, 0, 0, 0);
    req_valid = 4'b1001;
    sample(1'b1);
    cycle(1'b1);
    tests_run++;
    if (ack_order.size() != 1 || ack_order[0] != 0) begin
      tests_failed++;
      $display("FAIL rstmid_fresh: got %0d acks first %0d expected 1 0", ack_order.size(), ack_order.size() > 0 ? ack_order[0] : -1);
    end
  endtask

`ifdef NOC_ARB_WDOG_EN
  task automatic test_wdog();
    do_reset();
    set_req(0, 0, 0, 4);
    req_valid = 4'b0001;
    sample(1'b1);
    cycle(1'b1);
    cycle(1'b1);
    step();
    src_valid[0] = 1'b0;
    sample(1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cycle(1'b1);
      tests_run++;
      if (stream_out_TVALID !== 1'b0) begin
        tests_failed++;
        $display("FAIL wdog_stall%0d: got valid %b expected 0", i, stream_out_TVALID);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1);
      tests_run++;
      if (stream_out_TVALID !== 1'b1 || stream_out_TDATA !== 32'd0 ||
          stream_out_TLAST !== (i == 2) || src_ready !== 4'b0000) begin
        tests_failed++;
        $display("FAIL wdog_pad%0d: got v%b d%h l%b r%b expected v1 d0 l%b r0000", i, stream_out_TVALID, stream_out_TDATA, stream_out_TLAST, src_ready, (i == 2));
      end
    end
    cycle(1'b1);
    tests_run++;
    if (wdog_err !== 1'b1 || busy !== 1'b0 || beat_d.size() != 5) begin
      tests_failed++;
      $display("FAIL wdog_end: got err %b busy %b beats %0d expected 1 0 5", wdog_err, busy, beat_d.size());
    end
  endtask
`else
  task automatic test_wdog();
    tests_run++;
    if (wdog_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL wdog_tied: got %b expected 0", wdog_err);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_len_zero();
    test_backpressure();
    test_reset_mid();
    test_wdog();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
